// File: rtl/stack_mc_ctrl.sv
// Multicycle control unit for the 3-bit-opcode stack processor.
// Sequences fetch, operand pops, ALU pushes, memory push/pop and jumps.
// Tracks stack occupancy and traps on underflow, overflow or memory timeout.
//
// Memory handshake: mem_read / mem_write act as "valid" and stay high in
// FETCH, MEM_RD and MEM_WR until the cycle in which mem_ready is sampled
// high. That cycle is the transfer cycle. Its completion strobes (ir_write,
// pc_write, mdr_en, pop) are asserted in the same cycle. If mem_ready stays
// low for TIMEOUT cycles in one wait state, the last of those cycles drives
// no strobes and the unit moves to TRAP.
module stack_mc_ctrl #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    opcode,
    input  logic          mem_ready,
    input  logic          tos_zero,
    output logic          mem_read,
    output logic          mem_write,
    output logic          addr_src,
    output logic          ir_write,
    output logic          pc_write,
    output logic          jump,
    output logic          load_a,
    output logic          load_b,
    output logic          mdr_en,
    output logic          push,
    output logic          pop,
    output logic          stack_src,
    output logic [1:0]    alu_control,
    output logic [CW-1:0] sp_count,
    output logic          halted,
    output logic [1:0]    error,
    output logic [3:0]    dbg_state
);

    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_LOAD_A   = 4'd2;
    localparam logic [3:0] S_LOAD_B   = 4'd3;
    localparam logic [3:0] S_OP1      = 4'd4;
    localparam logic [3:0] S_OP2      = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_PUSH_MDR = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_TRAP     = 4'd10;

    localparam logic [1:0] E_NONE      = 2'b00;
    localparam logic [1:0] E_UNDERFLOW = 2'b01;
    localparam logic [1:0] E_OVERFLOW  = 2'b10;
    localparam logic [1:0] E_TIMEOUT   = 2'b11;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] sp_q, sp_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1:0]    err_q, err_d;

    logic waiting, timed_out, underflow, overflow;
    logic mrd_c, mwr_c, asrc_c, irw_c, pcw_c, jmp_c;
    logic lda_c, ldb_c, mdr_c, push_c, pop_c, ssrc_c;
    logic [1:0] alu_c;

    // Next-state, trap detection and raw strobe decode
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        mrd_c     = 1'b0;
        mwr_c     = 1'b0;
        asrc_c    = 1'b0;
        irw_c     = 1'b0;
        pcw_c     = 1'b0;
        jmp_c     = 1'b0;
        lda_c     = 1'b0;
        ldb_c     = 1'b0;
        mdr_c     = 1'b0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        ssrc_c    = 1'b0;
        alu_c     = 2'b00;
        waiting   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        // The TIMEOUT-th consecutive idle cycle traps; a ready on that cycle still wins.
        timed_out = waiting && !mem_ready && (wait_q == WW'(TIMEOUT - 1));
        underflow = 1'b0;
        overflow  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (timed_out) begin
                    state_d = S_TRAP;
                    err_d   = E_TIMEOUT;
                end else begin
                    mrd_c = 1'b1;
                    if (mem_ready) begin
                        irw_c   = 1'b1;
                        pcw_c   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    3'b000, 3'b001, 3'b010: underflow = (sp_q < CW'(2));
                    3'b011, 3'b101, 3'b111: underflow = (sp_q == '0);
                    3'b100:                 overflow  = (sp_q == CW'(DEPTH));
                    default: ;
                endcase
                if (underflow) begin
                    state_d = S_TRAP;
                    err_d   = E_UNDERFLOW;
                end else if (overflow) begin
                    state_d = S_TRAP;
                    err_d   = E_OVERFLOW;
                end else if (!opcode[2]) begin
                    state_d = S_LOAD_A;
                end else if (opcode[1]) begin
                    state_d = S_JUMP;
                end else if (opcode[0]) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_LOAD_A: begin
                pop_c   = 1'b1;
                lda_c   = 1'b1;
                state_d = (opcode == 3'b011) ? S_OP1 : S_LOAD_B;
            end
            S_LOAD_B: begin
                pop_c   = 1'b1;
                ldb_c   = 1'b1;
                state_d = S_OP2;
            end
            S_OP1, S_OP2: begin
                push_c  = 1'b1;
                alu_c   = opcode[1:0];
                state_d = S_FETCH;
            end
            S_MEM_RD: begin
                if (timed_out) begin
                    state_d = S_TRAP;
                    err_d   = E_TIMEOUT;
                end else begin
                    asrc_c = 1'b1;
                    mrd_c  = 1'b1;
                    if (mem_ready) begin
                        mdr_c   = 1'b1;
                        state_d = S_PUSH_MDR;
                    end
                end
            end
            S_PUSH_MDR: begin
                push_c  = 1'b1;
                ssrc_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                if (timed_out) begin
                    state_d = S_TRAP;
                    err_d   = E_TIMEOUT;
                end else begin
                    asrc_c = 1'b1;
                    mwr_c  = 1'b1;
                    if (mem_ready) begin
                        pop_c   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_JUMP: begin
                // JMP always loads the IR address; JZ only when top of stack is zero.
                jmp_c   = (opcode == 3'b110) ? 1'b1 : tos_zero;
                pcw_c   = (opcode == 3'b110) ? 1'b1 : tos_zero;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Occupancy never wraps: DECODE already refused any illegal pop/push.
        if (push_c) begin
            sp_d = sp_q + CW'(1);
        end else if (pop_c) begin
            sp_d = sp_q - CW'(1);
        end else begin
            sp_d = sp_q;
        end

        // Counter is zero whenever a wait state is entered, so it only counts idle cycles.
        if (waiting && !mem_ready && !timed_out) begin
            wait_d = wait_q + WW'(1);
        end else begin
            wait_d = '0;
        end
    end

    // State, occupancy, wait counter and trap cause registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            sp_q    <= '0;
            wait_q  <= '0;
            err_q   <= E_NONE;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Strobes are silenced while reset is held so the datapath sees nothing during reset.
    assign mem_read    = reset_n & mrd_c;
    assign mem_write   = reset_n & mwr_c;
    assign addr_src    = reset_n & asrc_c;
    assign ir_write    = reset_n & irw_c;
    assign pc_write    = reset_n & pcw_c;
    assign jump        = reset_n & jmp_c;
    assign load_a      = reset_n & lda_c;
    assign load_b      = reset_n & ldb_c;
    assign mdr_en      = reset_n & mdr_c;
    assign push        = reset_n & push_c;
    assign pop         = reset_n & pop_c;
    assign stack_src   = reset_n & ssrc_c;
    assign alu_control = reset_n ? alu_c : 2'b00;
    assign sp_count    = sp_q;
    assign halted      = (state_q == S_TRAP);
    assign error       = err_q;
    assign dbg_state   = state_q;

endmodule
